// File: rtl/uart_mem_sender.sv
// uart_mem_sender: walks a memory range and transmits each word as an 8-byte little-endian address/data UART record.
module uart_mem_sender #(
  parameter int CLK_HZ     = 50000000,
  parameter int SCLK_HZ    = 115200,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int BANK       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  uart_txd
);
  localparam int DIV = CLK_HZ / SCLK_HZ;
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, NEXT} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH:0] rem;
  logic [63:0] shreg;
  logic [DW-1:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [2:0] byte_cnt;
  logic zero_done;
  logic [7:0] cur;
  logic [31:0] afield;
  logic bit_end, frame_end, last, accept;
  assign cur       = shreg[7:0];
  assign afield    = (32'(BANK) << ADDR_WIDTH) | 32'(mem_r_addr);
  assign bit_end   = div_cnt == DW'(DIV - 1);
  assign frame_end = bit_end && bit_cnt == 4'd9;
  assign last      = rem == (ADDR_WIDTH + 1)'(1);
  assign accept    = state == IDLE && start && |count;
  assign done      = zero_done || (state == NEXT && last);
  assign busy      = state != IDLE && !(state == NEXT && last);
  assign uart_txd  = state != SEND || (bit_cnt == 4'd0 ? 1'b0 : bit_cnt == 4'd9 ? 1'b1 : cur[3'(bit_cnt - 4'd1)]);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? READ : IDLE;
      READ: state_nx = WAIT;
      WAIT: state_nx = SEND;
      SEND: state_nx = frame_end && byte_cnt == 3'd7 ? NEXT : SEND;
      NEXT: state_nx = last ? IDLE : READ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      mem_r_addr <= '0;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      zero_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      zero_done <= state == IDLE && start && !(|count);
      if (accept) begin
        mem_r_addr <= start_addr;
        rem        <= count;
      end
      if (state == WAIT) begin
        shreg    <= {32'(mem_r_data), afield};
        div_cnt  <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end
      if (state == SEND) begin
        div_cnt <= bit_end ? '0 : DW'(div_cnt + 1'b1);
        if (bit_end) begin
          bit_cnt <= frame_end ? 4'd0 : bit_cnt + 4'd1;
          if (frame_end) begin
            byte_cnt <= byte_cnt + 3'd1;
            shreg    <= shreg >> 8;
          end
        end
      end
      // the address only advances when another word follows, so it holds after the last read
      if (state == NEXT && !last) begin
        rem        <= (ADDR_WIDTH + 1)'(rem - 1);
        mem_r_addr <= ADDR_WIDTH'(mem_r_addr + 1);
      end
    end
  end
endmodule
